// File: rtl/uart_rx_fsm_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm_if
// Bundles the serial input line and the byte-delivery outputs of the UART
// receiver so the receiver, its driver and its consumer share one connection.
//
//   rx_serial      serial line into the receiver (idle = 1)
//   uart_rx_done   1-cycle pulse: uart_rx_data holds a new good byte
//   uart_rx_data   last good byte, stable between done pulses
//   uart_rx_busy   receiver is somewhere inside a frame
//   framing_error  1-cycle pulse: stop bit sampled as 0
//
// Modports:
//   slave   - the receiver itself (consumes rx_serial, produces the rest)
//   master  - the line driver / byte consumer on the other side
// ---------------------------------------------------------------------------
interface uart_rx_fsm_if;
  logic       rx_serial;
  logic       uart_rx_done;
  logic [7:0] uart_rx_data;
  logic       uart_rx_busy;
  logic       framing_error;

  modport slave (
    input  rx_serial,
    output uart_rx_done,
    output uart_rx_data,
    output uart_rx_busy,
    output framing_error
  );

  modport master (
    output rx_serial,
    input  uart_rx_done,
    input  uart_rx_data,
    input  uart_rx_busy,
    input  framing_error
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
// Serial-to-parallel UART receiver, 8N1 framing, LSB first, idle-high line.
// The line is synchronised through two flops, then a clocks-per-bit counter
// walks the frame so each bit is sampled near its midpoint. A good byte is
// presented on uart_rx_data with a single-cycle uart_rx_done pulse; a stop
// bit sampled low gives a single-cycle framing_error pulse instead and the
// receiver then waits for the line to return high before looking for the
// next start bit.
//
// Parameters:
//   CLKS_PER_BIT   clk cycles per serial bit (>= 4)
//
// Ports:
//   clk    in   system clock, all state on posedge
//   rstn   in   asynchronous active-low reset
//   rx_if  slave modport of uart_rx_fsm_if
//            rx_serial in; uart_rx_done, uart_rx_data[7:0],
//            uart_rx_busy, framing_error out
// ---------------------------------------------------------------------------
module uart_rx_fsm #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic          clk,
  input  logic          rstn,
  uart_rx_fsm_if.slave  rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // Last count value of a full bit period, and the count at which the start
  // bit is re-checked (its midpoint).
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4,
    S_BREAK   = 3'd5
  } state_e;

  // Synchroniser
  logic             rx_meta_q;
  logic             rx_sync_q;

  // Control
  state_e           state_q,   state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             done_q,    done_d;
  logic             ferr_q,    ferr_d;

  // Data
  logic [7:0]       shift_q,   shift_d;
  logic [7:0]       data_q,    data_d;

  // ---- stage: line synchroniser -------------------------------------------
  // Both flops reset high so a line held low through reset is not taken as a
  // start bit until it has actually been seen going through the flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_if.rx_serial;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---- stage: frame state machine, next-state logic ------------------------
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_sync_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          // A start bit that is no longer low at its midpoint was a glitch.
          state_d   = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_sync_q;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          if (rx_sync_q) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = S_CLEANUP;
          end else begin
            // Output byte is left untouched on a bad frame.
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_CLEANUP: begin
        state_d = S_IDLE;
      end

      S_BREAK: begin
        // A line held low after a bad stop bit must not look like a new
        // start bit; only a return to idle re-arms the receiver.
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // ---- stage: frame state machine, registers -------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      data_q    <= data_d;
    end
  end

  // The shift register is only ever read after all eight bits of the
  // current frame have been written, so it needs no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // ---- stage: outputs ------------------------------------------------------
  assign rx_if.uart_rx_done  = done_q;
  assign rx_if.uart_rx_data  = data_q;
  assign rx_if.framing_error = ferr_q;
  assign rx_if.uart_rx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fsm
// Drives serial frames into two receivers (16 and 4 clocks per bit) and
// compares received bytes, pulse timing and busy windows with an
// arithmetic model of the frame timing.
// ---------------------------------------------------------------------------
module tb_uart_rx_fsm;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_fsm_if if16();
  uart_rx_fsm_if if4();

  uart_rx_fsm #(.CLKS_PER_BIT(16)) dut16 (.clk(clk), .rstn(rstn), .rx_if(if16.slave));
  uart_rx_fsm #(.CLKS_PER_BIT(4))  dut4  (.clk(clk), .rstn(rstn), .rx_if(if4.slave));

  int tests = 0;
  int fails = 0;

  // Observed events
  int         d16_cyc[$];
  logic [7:0] d16_dat[$];
  int         e16_cyc[$];
  int         d4_cyc[$];
  logic [7:0] d4_dat[$];
  int         e4_cyc[$];
  int         overlap = 0;
  logic       busy16_prev = 1'b0;
  int         rise16 = -1;
  int         fall16 = -1;

  always @(negedge clk) begin
    if (if16.uart_rx_done === 1'b1) begin
      d16_cyc.push_back(cyc);
      d16_dat.push_back(if16.uart_rx_data);
    end
    if (if16.framing_error === 1'b1) e16_cyc.push_back(cyc);
    if (if4.uart_rx_done === 1'b1) begin
      d4_cyc.push_back(cyc);
      d4_dat.push_back(if4.uart_rx_data);
    end
    if (if4.framing_error === 1'b1) e4_cyc.push_back(cyc);
    if ((if16.uart_rx_done && if16.framing_error) || (if4.uart_rx_done && if4.framing_error))
      overlap <= overlap + 1;
    if (if16.uart_rx_busy === 1'b1 && !busy16_prev) rise16 <= cyc;
    if (if16.uart_rx_busy === 1'b0 && busy16_prev)  fall16 <= cyc;
    busy16_prev <= (if16.uart_rx_busy === 1'b1);
  end

  // ---------------------------------------------------------------- helpers
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  task automatic set_rx(input bit sel4, input logic v);
    if (sel4) if4.rx_serial = v;
    else      if16.rx_serial = v;
  endtask

  task automatic clear_events();
    d16_cyc.delete(); d16_dat.delete(); e16_cyc.delete();
    d4_cyc.delete();  d4_dat.delete();  e4_cyc.delete();
  endtask

  // Called aligned (just after a posedge); start_cyc is the cycle in which
  // the line first goes low.
  task automatic send_frame(input bit sel4, input logic [7:0] b, input logic stop,
                            input int stop_len, output int start_cyc);
    int cpb;
    cpb = sel4 ? 4 : 16;
    start_cyc = cyc;
    set_rx(sel4, 1'b0);
    wait_cycles(cpb);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel4, b[i]);
      wait_cycles(cpb);
    end
    set_rx(sel4, stop);
    wait_cycles(stop_len);
  endtask

  // Line low in cycle s -> receiver first sees it two cycles later (c0);
  // the result pulse follows HALF + 9 bit periods + 2 cycles after c0.
  function automatic int exp_done_cyc(input bit sel4, input int s);
    int cpb;
    cpb = sel4 ? 4 : 16;
    return s + 2 + (cpb - 1) / 2 + 9 * cpb + 2;
  endfunction

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rstn = 1'b0;
    if16.rx_serial = 1'b1;
    if4.rx_serial  = 1'b1;
    wait_cycles(3);
    tests++; if (if16.uart_rx_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", if16.uart_rx_done); end
    tests++; if (if16.uart_rx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", if16.uart_rx_data); end
    tests++; if (if16.uart_rx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", if16.uart_rx_busy); end
    tests++; if (if16.framing_error !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b expected 0", if16.framing_error); end
    tests++; if (if4.uart_rx_busy !== 1'b0 || if4.uart_rx_data !== 8'h00) begin
      fails++; $display("FAIL reset_dut4: got busy %b data %h expected 0 00", if4.uart_rx_busy, if4.uart_rx_data); end
    rstn = 1'b1;
    wait_cycles(4);
  endtask

  task automatic test_frame_a5();
    int s, e;
    clear_events();
    send_frame(1'b0, 8'hA5, 1'b1, 16, s);
    wait_cycles(32);
    e = exp_done_cyc(1'b0, s);
    tests++; if (d16_cyc.size() !== 1) begin fails++; $display("FAIL a5_count: got %0d expected 1", d16_cyc.size()); end
    if (d16_cyc.size() >= 1) begin
      tests++; if (d16_dat[0] !== 8'hA5) begin fails++; $display("FAIL a5_data: got %h expected a5", d16_dat[0]); end
      tests++; if (d16_cyc[0] !== e) begin fails++; $display("FAIL a5_time: got %0d expected %0d", d16_cyc[0] - s, e - s); end
    end
    tests++; if (e16_cyc.size() !== 0) begin fails++; $display("FAIL a5_ferr: got %0d expected 0", e16_cyc.size()); end
    tests++; if (rise16 !== s + 3) begin fails++; $display("FAIL a5_busy_rise: got %0d expected %0d", rise16 - s, 3); end
    tests++; if (fall16 !== e + 1) begin fails++; $display("FAIL a5_busy_fall: got %0d expected %0d", fall16 - s, e + 1 - s); end
    tests++; if (if16.uart_rx_data !== 8'hA5) begin fails++; $display("FAIL a5_hold: got %h expected a5", if16.uart_rx_data); end
  endtask

  task automatic test_glitch();
    int s;
    clear_events();
    s = cyc;
    if16.rx_serial = 1'b0;
    wait_cycles(4);
    if16.rx_serial = 1'b1;
    wait_cycles(40);
    tests++; if (d16_cyc.size() !== 0 || e16_cyc.size() !== 0) begin
      fails++; $display("FAIL glitch_pulses: got done %0d ferr %0d expected 0 0", d16_cyc.size(), e16_cyc.size()); end
    tests++; if (rise16 !== s + 3) begin fails++; $display("FAIL glitch_busy_rise: got %0d expected 3", rise16 - s); end
    tests++; if (fall16 !== s + 11) begin fails++; $display("FAIL glitch_busy_fall: got %0d expected 11", fall16 - s); end
    tests++; if (if16.uart_rx_busy !== 1'b0) begin fails++; $display("FAIL glitch_idle: got %b expected 0", if16.uart_rx_busy); end
  endtask

  task automatic test_framing();
    int s1, s2;
    clear_events();
    send_frame(1'b0, 8'h11, 1'b1, 16, s1);
    wait_cycles(32);
    send_frame(1'b0, 8'h3C, 1'b0, 40, s2);
    if16.rx_serial = 1'b1;
    wait_cycles(320);
    tests++; if (d16_cyc.size() !== 1) begin fails++; $display("FAIL ferr_done_count: got %0d expected 1", d16_cyc.size()); end
    tests++; if (e16_cyc.size() !== 1) begin fails++; $display("FAIL ferr_count: got %0d expected 1", e16_cyc.size()); end
    if (e16_cyc.size() >= 1) begin
      tests++; if (e16_cyc[0] !== exp_done_cyc(1'b0, s2)) begin
        fails++; $display("FAIL ferr_time: got %0d expected %0d", e16_cyc[0] - s2, exp_done_cyc(1'b0, s2) - s2); end
    end
    tests++; if (if16.uart_rx_data !== 8'h11) begin fails++; $display("FAIL ferr_data_hold: got %h expected 11", if16.uart_rx_data); end
    tests++; if (if16.uart_rx_busy !== 1'b0) begin fails++; $display("FAIL ferr_idle: got %b expected 0", if16.uart_rx_busy); end
  endtask

  task automatic test_back_to_back();
    int starts[16];
    clear_events();
    for (int i = 0; i < 16; i++) send_frame(1'b0, 8'(i), 1'b1, 16, starts[i]);
    wait_cycles(48);
    tests++; if (d16_cyc.size() !== 16) begin fails++; $display("FAIL b2b_count: got %0d expected 16", d16_cyc.size()); end
    for (int i = 0; i < 16 && i < d16_cyc.size(); i++) begin
      tests++; if (d16_dat[i] !== 8'(i)) begin fails++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, d16_dat[i], 8'(i)); end
      tests++; if (d16_cyc[i] !== exp_done_cyc(1'b0, starts[i])) begin
        fails++; $display("FAIL b2b_time[%0d]: got %0d expected %0d", i, d16_cyc[i], exp_done_cyc(1'b0, starts[i])); end
    end
    tests++; if (e16_cyc.size() !== 0) begin fails++; $display("FAIL b2b_ferr: got %0d expected 0", e16_cyc.size()); end
  endtask

  task automatic test_reset_midframe();
    int s;
    clear_events();
    if16.rx_serial = 1'b0;
    wait_cycles(16);
    for (int i = 0; i < 3; i++) begin
      if16.rx_serial = 1'b1;
      wait_cycles(16);
    end
    wait_cycles(8);
    tests++; if (if16.uart_rx_busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %b expected 1", if16.uart_rx_busy); end
    rstn = 1'b0;
    #1;
    tests++; if (if16.uart_rx_busy !== 1'b0 || if16.uart_rx_done !== 1'b0 || if16.framing_error !== 1'b0) begin
      fails++; $display("FAIL mid_reset_ctrl: got busy %b done %b ferr %b expected 0 0 0",
                        if16.uart_rx_busy, if16.uart_rx_done, if16.framing_error); end
    tests++; if (if16.uart_rx_data !== 8'h00) begin fails++; $display("FAIL mid_reset_data: got %h expected 00", if16.uart_rx_data); end
    wait_cycles(3);
    rstn = 1'b1;
    wait_cycles(200);
    tests++; if (d16_cyc.size() !== 0) begin fails++; $display("FAIL mid_no_done: got %0d expected 0", d16_cyc.size()); end
    send_frame(1'b0, 8'h00, 1'b1, 16, s);
    wait_cycles(32);
    tests++; if (d16_cyc.size() !== 1) begin fails++; $display("FAIL mid_after_count: got %0d expected 1", d16_cyc.size()); end
    if (d16_cyc.size() >= 1) begin
      tests++; if (d16_dat[0] !== 8'h00 || d16_cyc[0] !== exp_done_cyc(1'b0, s)) begin
        fails++; $display("FAIL mid_after_frame: got %h at %0d expected 00 at %0d", d16_dat[0], d16_cyc[0] - s, exp_done_cyc(1'b0, s) - s); end
    end
  endtask

  task automatic test_patterns();
    int s0, s1, s2;
    clear_events();
    send_frame(1'b0, 8'h00, 1'b1, 16, s0);
    send_frame(1'b0, 8'hFF, 1'b1, 16, s1);
    send_frame(1'b1, 8'h5A, 1'b1, 4, s2);
    wait_cycles(32);
    tests++; if (d16_cyc.size() !== 2) begin fails++; $display("FAIL pat16_count: got %0d expected 2", d16_cyc.size()); end
    if (d16_cyc.size() >= 2) begin
      tests++; if (d16_dat[0] !== 8'h00 || d16_cyc[0] !== exp_done_cyc(1'b0, s0)) begin
        fails++; $display("FAIL pat_00: got %h at %0d expected 00 at %0d", d16_dat[0], d16_cyc[0] - s0, exp_done_cyc(1'b0, s0) - s0); end
      tests++; if (d16_dat[1] !== 8'hFF || d16_cyc[1] !== exp_done_cyc(1'b0, s1)) begin
        fails++; $display("FAIL pat_ff: got %h at %0d expected ff at %0d", d16_dat[1], d16_cyc[1] - s1, exp_done_cyc(1'b0, s1) - s1); end
    end
    tests++; if (d4_cyc.size() !== 1) begin fails++; $display("FAIL pat4_count: got %0d expected 1", d4_cyc.size()); end
    if (d4_cyc.size() >= 1) begin
      tests++; if (d4_dat[0] !== 8'h5A || d4_cyc[0] !== exp_done_cyc(1'b1, s2)) begin
        fails++; $display("FAIL pat4_5a: got %h at %0d expected 5a at %0d", d4_dat[0], d4_cyc[0] - s2, exp_done_cyc(1'b1, s2) - s2); end
    end
  endtask

  task automatic test_random(input bit sel4);
    logic [7:0] exp_dat[$];
    int         exp_cyc[$];
    int         s, n;
    logic [7:0] b;
    clear_events();
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      send_frame(sel4, b, 1'b1, sel4 ? 4 : 16, s);
      exp_dat.push_back(b);
      exp_cyc.push_back(exp_done_cyc(sel4, s));
      wait_cycles($urandom_range(0, 40));
    end
    wait_cycles(48);
    n = sel4 ? d4_cyc.size() : d16_cyc.size();
    tests++; if (n !== 20) begin fails++; $display("FAIL rand%0d_count: got %0d expected 20", sel4 ? 4 : 16, n); end
    for (int i = 0; i < 20 && i < n; i++) begin
      tests++;
      if ((sel4 ? d4_dat[i] : d16_dat[i]) !== exp_dat[i] || (sel4 ? d4_cyc[i] : d16_cyc[i]) !== exp_cyc[i]) begin
        fails++;
        $display("FAIL rand%0d[%0d]: got %h at %0d expected %h at %0d", sel4 ? 4 : 16, i,
                 sel4 ? d4_dat[i] : d16_dat[i], sel4 ? d4_cyc[i] : d16_cyc[i], exp_dat[i], exp_cyc[i]);
      end
    end
    n = sel4 ? e4_cyc.size() : e16_cyc.size();
    tests++; if (n !== 0) begin fails++; $display("FAIL rand%0d_ferr: got %0d expected 0", sel4 ? 4 : 16, n); end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    test_patterns();
    test_random(1'b0);
    test_random(1'b1);
    tests++; if (overlap !== 0) begin fails++; $display("FAIL pulse_overlap: got %0d expected 0", overlap); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
